// File: rtl/vga_pkg.sv
// Shared constants for the VGA cursor control slice: register map, CSR bit
// positions, field widths and default text-mode geometry.
package vga_pkg;

  localparam int unsigned DEF_COLS         = 80;
  localparam int unsigned DEF_ROWS         = 25;
  localparam int unsigned DEF_FLASH_FRAMES = 32;

  localparam int unsigned ADR_W = 16;
  localparam int unsigned DAT_W = 16;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned COL_W = 7;
  localparam int unsigned ROW_W = 5;
  localparam int unsigned CUR_W = 11;
  localparam int unsigned FRM_W = 16;

  // Word-register indices (byte address bits [2:1])
  localparam logic [1:0] REG_CSR = 2'd0;
  localparam logic [1:0] REG_POS = 2'd1;
  localparam logic [1:0] REG_ADV = 2'd2;
  localparam logic [1:0] REG_FRM = 2'd3;

  // CSR bit positions
  localparam int unsigned CSR_ON    = 0;
  localparam int unsigned CSR_TYPE  = 1;
  localparam int unsigned CSR_BLINK = 2;
  localparam int unsigned CSR_IE    = 3;
  localparam int unsigned CSR_SCR   = 15;

  // POS field placement
  localparam int unsigned POS_ROW_LSB = 8;

  // Saturate a 7-bit field to a maximum value
  function automatic logic [6:0] sat7(input logic [6:0] v, input logic [6:0] max_v);
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/vga_cursor_ctrl_if.sv
// Wishbone slave bus bundle for vga_cursor_ctrl.
//   adr   byte address, bits [2:1] select the register
//   dat_w write data (master -> slave)
//   dat_r read data (slave -> master)
//   cyc, stb, we, sel  standard Wishbone request qualifiers
//   ack   access acknowledge
interface vga_cursor_ctrl_if;
  import vga_pkg::*;

  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] dat_w;
  logic [DAT_W-1:0] dat_r;
  logic             cyc;
  logic             stb;
  logic             we;
  logic [SEL_W-1:0] sel;
  logic             ack;

  modport master (output adr, dat_w, cyc, stb, we, sel, input dat_r, ack);
  modport slave  (input adr, dat_w, cyc, stb, we, sel, output dat_r, ack);

endinterface

// File: rtl/vga_vsync_sync.sv
// vsync synchronizer, rising-edge detector and flash divider.
//   wb_clk_i       bus clock
//   wb_rst_n       synchronous active-low reset
//   vsync_i        adapter vsync, asynchronous
//   frame_pulse_c  one-cycle pulse per vsync rising edge (combinational from flops)
//   flash          toggles every FLASH_FRAMES frame pulses
module vga_vsync_sync #(
  parameter int unsigned FLASH_FRAMES = 32
) (
  input  logic wb_clk_i,
  input  logic wb_rst_n,
  input  logic vsync_i,
  output logic frame_pulse_c,
  output logic flash
);

  localparam int unsigned DIV_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FLASH_FRAMES - 1);

  logic [2:0]       vs_q;
  logic [DIV_W-1:0] div_q;

  // Edge seen between the second (synchronized) and third flop
  assign frame_pulse_c = vs_q[1] & ~vs_q[2];

  // Synchronizer chain and frame divider
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      vs_q  <= '0;
      div_q <= '0;
      flash <= 1'b0;
    end else begin
      vs_q <= {vs_q[1:0], vsync_i};
      if (frame_pulse_c) begin
        if (div_q == DIV_LAST) begin
          div_q <= '0;
          flash <= ~flash;
        end else begin
          div_q <= div_q + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/vga_cursor_ctrl.sv
// Wishbone cursor control unit for the text VGA adapter.
// Holds cursor row/col, produces the linear cursor address, cursor_on,
// cursor_type, flash and a sticky scroll request; counts vsync frames.
//   wb_clk_i, wb_rst_n  clock, synchronous active-low reset
//   wb                  Wishbone slave bundle (vga_cursor_ctrl_if.slave)
//   vsync_i             adapter vsync, asynchronous
//   cursor              row*COLS + col
//   cursor_on           ON & (~BLINK | flash)
//   cursor_type         0 underline, 1 block
//   flash               blink phase
//   scroll_req          sticky CSR.SCR level
//   irq                 frame interrupt
// Optional feature macro: VGA_CURSOR_CTRL_IRQ_EN (enables CSR.IE and irq).
module vga_cursor_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned COLS         = DEF_COLS,
  parameter int unsigned ROWS         = DEF_ROWS,
  parameter int unsigned FLASH_FRAMES = DEF_FLASH_FRAMES
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  vga_cursor_ctrl_if.slave  wb,
  input  logic              vsync_i,
  output logic [CUR_W-1:0]  cursor,
  output logic              cursor_on,
  output logic              cursor_type,
  output logic              flash,
  output logic              scroll_req,
  output logic              irq
);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);

  logic             req_c, wr_c, rd_c;
  logic [1:0]       rsel_c;
  logic             csr_wr_c, pos_wr_c, adv_wr_c;
  logic             frame_pulse_c;
  logic             csr_on, csr_type, csr_blink, csr_scr, csr_ie;
  logic [COL_W-1:0] col_q, col_nxt_c;
  logic [ROW_W-1:0] row_q, row_nxt_c;
  logic             scr_nxt_c;
  logic [FRM_W-1:0] frm_q;
  logic [CUR_W-1:0] cur_nxt_c;
  logic [DAT_W-1:0] rd_data_c;
  logic             unused_bits;

  // Address bits outside [2:1] and data bits outside the register fields are ignored
  assign unused_bits = ^{wb.adr, wb.dat_w};

  // A new request is only accepted while ack is low
  assign req_c    = wb.cyc & wb.stb & ~wb.ack;
  assign rsel_c   = wb.adr[2:1];
  assign wr_c     = req_c & wb.we;
  assign rd_c     = req_c & ~wb.we;
  assign csr_wr_c = wr_c && (rsel_c == REG_CSR);
  assign pos_wr_c = wr_c && (rsel_c == REG_POS);
  assign adv_wr_c = wr_c && (rsel_c == REG_ADV);

  assign cursor_type = csr_type;
  assign scroll_req  = csr_scr;

  vga_vsync_sync #(.FLASH_FRAMES(FLASH_FRAMES)) u_vsync (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_n      (wb_rst_n),
    .vsync_i       (vsync_i),
    .frame_pulse_c (frame_pulse_c),
    .flash         (flash)
  );

  // Cursor position and scroll-request next state; an advance setting SCR wins over a clear
  always_comb begin
    col_nxt_c = col_q;
    row_nxt_c = row_q;
    scr_nxt_c = csr_scr;
    if (csr_wr_c && wb.sel[1] && wb.dat_w[CSR_SCR]) scr_nxt_c = 1'b0;
    if (pos_wr_c) begin
      if (wb.sel[0]) col_nxt_c = sat7(wb.dat_w[6:0], COL_MAX);
      if (wb.sel[1]) row_nxt_c = ROW_W'(sat7({2'b00, wb.dat_w[12:8]}, 7'(ROW_MAX)));
    end
    if (adv_wr_c) begin
      if (col_q < COL_MAX) begin
        col_nxt_c = col_q + COL_W'(1);
      end else begin
        col_nxt_c = '0;
        if (row_q < ROW_MAX) row_nxt_c = row_q + ROW_W'(1);
        else                 scr_nxt_c = 1'b1;
      end
    end
  end

  // Linear address: shift-add for the standard 80-column mode
  generate
    if (COLS == 80) begin : gen_mul80
      assign cur_nxt_c = (CUR_W'(row_q) << 6) + (CUR_W'(row_q) << 4) + CUR_W'(col_q);
    end else begin : gen_mul
      assign cur_nxt_c = CUR_W'(32'(row_q) * COLS) + CUR_W'(col_q);
    end
  endgenerate

  // Read-data mux
  always_comb begin
    rd_data_c = '0;
    case (rsel_c)
      REG_CSR: begin
        rd_data_c[CSR_ON]    = csr_on;
        rd_data_c[CSR_TYPE]  = csr_type;
        rd_data_c[CSR_BLINK] = csr_blink;
        rd_data_c[CSR_IE]    = csr_ie;
        rd_data_c[CSR_SCR]   = csr_scr;
      end
      REG_POS: begin
        rd_data_c[6:0]  = col_q;
        rd_data_c[12:8] = row_q;
      end
      REG_FRM: rd_data_c = frm_q;
      default: rd_data_c = '0;
    endcase
  end

  // Bus response, registers, frame counter and output flops
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      wb.ack    <= 1'b0;
      wb.dat_r  <= '0;
      csr_on    <= 1'b0;
      csr_type  <= 1'b0;
      csr_blink <= 1'b0;
      csr_scr   <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      frm_q     <= '0;
      cursor    <= '0;
      cursor_on <= 1'b0;
    end else begin
      wb.ack <= req_c;
      if (rd_c) wb.dat_r <= rd_data_c;
      if (csr_wr_c && wb.sel[0]) begin
        csr_on    <= wb.dat_w[CSR_ON];
        csr_type  <= wb.dat_w[CSR_TYPE];
        csr_blink <= wb.dat_w[CSR_BLINK];
      end
      csr_scr   <= scr_nxt_c;
      col_q     <= col_nxt_c;
      row_q     <= row_nxt_c;
      if (frame_pulse_c) frm_q <= frm_q + FRM_W'(1);
      cursor    <= cur_nxt_c;
      cursor_on <= csr_on & (~csr_blink | flash);
    end
  end

`ifdef VGA_CURSOR_CTRL_IRQ_EN
  logic frm_rd_c;
  assign frm_rd_c = rd_c && (rsel_c == REG_FRM);

  // Frame interrupt: set on frame pulse when enabled, cleared by FRM read; set wins
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      csr_ie <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (csr_wr_c && wb.sel[0]) csr_ie <= wb.dat_w[CSR_IE];
      if (frame_pulse_c && csr_ie) irq <= 1'b1;
      else if (frm_rd_c)           irq <= 1'b0;
    end
  end
`else
  assign csr_ie = 1'b0;
  assign irq    = 1'b0;
`endif

endmodule
